// File: rtl/decode_stage_pkg.sv
// rtl/decode_stage_pkg.sv - shared constants and types for the decode stage
// Purpose: icode values, register IDs, status encodings and the D-register
//          bubble value shared by decode_stage and regfile_2r2w.
// Ports:   none (package).
package decode_stage_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RSP   = 4'h4;

    localparam logic [1:0] STAT_AOK = 2'd0;
    localparam logic [1:0] STAT_HLT = 2'd1;
    localparam logic [1:0] STAT_ADR = 2'd2;
    localparam logic [1:0] STAT_INS = 2'd3;

    typedef struct packed {
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
        logic [1:0]  stat;
    } d_reg_t;

    localparam d_reg_t D_BUBBLE = '{
        icode: I_NOP,
        ifun:  4'h0,
        ra:    RNONE,
        rb:    RNONE,
        valc:  64'd0,
        valp:  64'd0,
        stat:  STAT_AOK
    };

endpackage

// File: rtl/regfile_2r2w.sv
// rtl/regfile_2r2w.sv - 15 x 64-bit register file, 2 async reads, 2 sync writes
// Purpose: general register file; ID F reads 0 and is never written. Reads
//          bypass same-cycle writes, with the M port taking priority over E.
// Ports:   clk, rst (async, active-high, clears all registers)
//          src_a/src_b -> val_a/val_b : combinational read ports
//          dst_e/val_e, dst_m/val_m   : write ports (RNONE = no write)
module regfile_2r2w
    import decode_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  src_a,
    input  logic [3:0]  src_b,
    output logic [63:0] val_a,
    output logic [63:0] val_b,
    input  logic [3:0]  dst_e,
    input  logic [63:0] val_e,
    input  logic [3:0]  dst_m,
    input  logic [63:0] val_m
);

    logic [63:0] regs [0:14];

    // Same-cycle bypass; M is checked first so it wins when both target one ID.
    function automatic logic [63:0] read_port(input logic [3:0] src);
        if (src == RNONE)
            return 64'd0;
        else if (src == dst_m)
            return val_m;
        else if (src == dst_e)
            return val_e;
        else
            return regs[src];
    endfunction

    always_comb begin
        val_a = read_port(src_a);
        val_b = read_port(src_b);
    end

    // M is written after E so it overrides on a shared destination.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 15; i++)
                regs[i] <= 64'd0;
        end else begin
            if (dst_e != RNONE)
                regs[dst_e] <= val_e;
            if (dst_m != RNONE)
                regs[dst_m] <= val_m;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - pipeline D register, operand decode and register read
// Purpose: holds the fetched instruction (stall/bubble control), derives the
//          source/destination register IDs and reads operands from the file.
// Ports:   clk, rst (async, active-high)
//          d_stall, d_bubble                   : D register control
//          f_icode/f_ifun/f_rA/f_rB/f_valC/f_valP/f_stat : fetched fields
//          w_dstE/w_valE, w_dstM/w_valM        : writeback
//          d_icode/d_ifun/d_stat/d_valC        : registered fields
//          d_srcA/d_srcB/d_dstE/d_dstM         : register IDs
//          d_valA/d_valB                       : combinational operands
module decode_stage
    import decode_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        d_stall,
    input  logic        d_bubble,
    input  logic [3:0]  f_icode,
    input  logic [3:0]  f_ifun,
    input  logic [3:0]  f_rA,
    input  logic [3:0]  f_rB,
    input  logic [63:0] f_valC,
    input  logic [63:0] f_valP,
    input  logic [1:0]  f_stat,
    input  logic [3:0]  w_dstE,
    input  logic [3:0]  w_dstM,
    input  logic [63:0] w_valE,
    input  logic [63:0] w_valM,
    output logic [3:0]  d_icode,
    output logic [3:0]  d_ifun,
    output logic [1:0]  d_stat,
    output logic [63:0] d_valC,
    output logic [3:0]  d_srcA,
    output logic [3:0]  d_srcB,
    output logic [3:0]  d_dstE,
    output logic [3:0]  d_dstM,
    output logic [63:0] d_valA,
    output logic [63:0] d_valB
);

    d_reg_t      d_reg;
    logic [63:0] rf_val_a;

    // Bubble wins over stall, so asserting both yields a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            d_reg <= D_BUBBLE;
        else if (d_bubble)
            d_reg <= D_BUBBLE;
        else if (!d_stall)
            d_reg <= '{icode: f_icode, ifun: f_ifun, ra: f_rA, rb: f_rB,
                       valc: f_valC, valp: f_valP, stat: f_stat};
    end

    assign d_icode = d_reg.icode;
    assign d_ifun  = d_reg.ifun;
    assign d_stat  = d_reg.stat;
    assign d_valC  = d_reg.valc;

    // Undefined icodes fall to the defaults, so every ID is RNONE and both
    // operands read as 0 through the ID-F read path.
    always_comb begin
        d_srcA = RNONE;
        d_srcB = RNONE;
        d_dstE = RNONE;
        d_dstM = RNONE;
        case (d_reg.icode)
            I_RRMOVQ, I_IRMOVQ: d_dstE = d_reg.rb;
            I_RMMOVQ: begin
                d_srcA = d_reg.ra;
                d_srcB = d_reg.rb;
            end
            I_MRMOVQ: begin
                d_srcB = d_reg.rb;
                d_dstM = d_reg.ra;
            end
            I_OPQ: begin
                d_srcA = d_reg.ra;
                d_srcB = d_reg.rb;
                d_dstE = d_reg.rb;
            end
            I_CALL: begin
                d_srcB = RSP;
                d_dstE = RSP;
            end
            I_RET: begin
                d_srcA = RSP;
                d_srcB = RSP;
                d_dstE = RSP;
            end
            I_PUSHQ: begin
                d_srcA = d_reg.ra;
                d_srcB = RSP;
                d_dstE = RSP;
            end
            I_POPQ: begin
                d_srcA = RSP;
                d_srcB = RSP;
                d_dstE = RSP;
                d_dstM = d_reg.ra;
            end
            default: ;
        endcase
        // rrmovq also reads rA; kept apart from the dstE arm above.
        if (d_reg.icode == I_RRMOVQ)
            d_srcA = d_reg.ra;
    end

    regfile_2r2w u_regfile (
        .clk   (clk),
        .rst   (rst),
        .src_a (d_srcA),
        .src_b (d_srcB),
        .val_a (rf_val_a),
        .val_b (d_valB),
        .dst_e (w_dstE),
        .val_e (w_valE),
        .dst_m (w_dstM),
        .val_m (w_valM)
    );

    // jXX and call carry the fall-through/return address in valA.
    assign d_valA = (d_reg.icode == I_JXX || d_reg.icode == I_CALL) ? d_reg.valp : rf_val_a;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed self-checking bench for decode_stage
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        d_stall, d_bubble;
    logic [3:0]  f_icode, f_ifun, f_rA, f_rB;
    logic [63:0] f_valC, f_valP;
    logic [1:0]  f_stat;
    logic [3:0]  w_dstE, w_dstM;
    logic [63:0] w_valE, w_valM;
    logic [3:0]  d_icode, d_ifun;
    logic [1:0]  d_stat;
    logic [63:0] d_valC;
    logic [3:0]  d_srcA, d_srcB, d_dstE, d_dstM;
    logic [63:0] d_valA, d_valB;

    int total = 0;
    int bad   = 0;

    decode_stage dut (
        .clk(clk), .rst(rst), .d_stall(d_stall), .d_bubble(d_bubble),
        .f_icode(f_icode), .f_ifun(f_ifun), .f_rA(f_rA), .f_rB(f_rB),
        .f_valC(f_valC), .f_valP(f_valP), .f_stat(f_stat),
        .w_dstE(w_dstE), .w_dstM(w_dstM), .w_valE(w_valE), .w_valM(w_valM),
        .d_icode(d_icode), .d_ifun(d_ifun), .d_stat(d_stat), .d_valC(d_valC),
        .d_srcA(d_srcA), .d_srcB(d_srcB), .d_dstE(d_dstE), .d_dstM(d_dstM),
        .d_valA(d_valA), .d_valB(d_valB)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_f(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                         input logic [3:0] rb, input logic [63:0] vc, input logic [63:0] vp,
                         input logic [1:0] st);
        f_icode = ic; f_ifun = fn; f_rA = ra; f_rB = rb;
        f_valC = vc; f_valP = vp; f_stat = st;
    endtask

    task automatic set_w(input logic [3:0] de, input logic [63:0] ve,
                         input logic [3:0] dm, input logic [63:0] vm);
        w_dstE = de; w_valE = ve; w_dstM = dm; w_valM = vm;
    endtask

    initial begin
        rst = 1'b1; d_stall = 1'b0; d_bubble = 1'b0;
        set_f(4'h0, 4'h0, 4'h0, 4'h0, 64'd0, 64'd0, 2'd0);
        set_w(4'hF, 64'd0, 4'hF, 64'd0);
        #1;
        chk("rst_icode", d_icode, 64'h1);
        chk("rst_stat", d_stat, 64'h0);
        chk("rst_srcA", d_srcA, 64'hF);
        chk("rst_valA", d_valA, 64'h0);
        #11 rst = 1'b0;

        // irmovq $0x11, %r2
        set_f(4'h3, 4'h0, 4'hF, 4'h2, 64'h11, 64'h0A, 2'd0);
        tick();
        chk("irm_icode", d_icode, 64'h3);
        chk("irm_dstE", d_dstE, 64'h2);
        chk("irm_srcA", d_srcA, 64'hF);
        chk("irm_srcB", d_srcB, 64'hF);
        chk("irm_valC", d_valC, 64'h11);

        // W writes r2=0x11 and r5=7 while rmmovq %r5,(%r2) loads
        set_w(4'h2, 64'h11, 4'h5, 64'h7);
        set_f(4'h4, 4'h0, 4'h5, 4'h2, 64'h0, 64'h14, 2'd0);
        tick();
        set_w(4'hF, 64'd0, 4'hF, 64'd0);
        #1;
        chk("rmm_srcA", d_srcA, 64'h5);
        chk("rmm_srcB", d_srcB, 64'h2);
        chk("rmm_valA", d_valA, 64'h7);
        chk("rmm_valB", d_valB, 64'h11);
        chk("rmm_dstE", d_dstE, 64'hF);
        chk("rmm_dstM", d_dstM, 64'hF);

        // opq %r3,%r3 with both writeback ports targeting r3
        set_f(4'h6, 4'h0, 4'h3, 4'h3, 64'h0, 64'h16, 2'd0);
        tick();
        chk("opq_valA_pre", d_valA, 64'h0);
        set_w(4'h3, 64'h1, 4'h3, 64'h2);
        #1;
        chk("wt_valA_Mwins", d_valA, 64'h2);
        chk("wt_valB_Mwins", d_valB, 64'h2);
        tick();
        set_w(4'hF, 64'd0, 4'hF, 64'd0);
        #1;
        chk("r3_after_edge", d_valA, 64'h2);
        set_w(4'h3, 64'h9, 4'hF, 64'd0);
        #1;
        chk("wt_valA_E", d_valA, 64'h9);

        // r4 (RSP) = 0x100, then popq %r6
        set_w(4'h4, 64'h100, 4'hF, 64'd0);
        set_f(4'hB, 4'h0, 4'h6, 4'hF, 64'h0, 64'h20, 2'd0);
        tick();
        set_w(4'hF, 64'd0, 4'hF, 64'd0);
        #1;
        chk("pop_srcA", d_srcA, 64'h4);
        chk("pop_srcB", d_srcB, 64'h4);
        chk("pop_dstE", d_dstE, 64'h4);
        chk("pop_dstM", d_dstM, 64'h6);
        chk("pop_valA", d_valA, 64'h100);

        // call with valP=0x2B
        set_f(4'h8, 4'h0, 4'hF, 4'hF, 64'h40, 64'h2B, 2'd0);
        tick();
        chk("call_valA", d_valA, 64'h2B);
        chk("call_valB", d_valB, 64'h100);
        chk("call_dstE", d_dstE, 64'h4);

        // stall for 3 cycles while fetch changes
        d_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_f(4'h2, 4'h1 + 4'(i), 4'h1, 4'h1, 64'h55 + 64'(i), 64'h60, 2'd1);
            tick();
            chk("stall_icode", d_icode, 64'h8);
            chk("stall_valC", d_valC, 64'h40);
            chk("stall_valA", d_valA, 64'h2B);
        end

        // stall + bubble acts as bubble
        d_bubble = 1'b1;
        tick();
        d_bubble = 1'b0; d_stall = 1'b0;
        chk("bub_icode", d_icode, 64'h1);
        chk("bub_ifun", d_ifun, 64'h0);
        chk("bub_valC", d_valC, 64'h0);
        chk("bub_srcA", d_srcA, 64'hF);
        chk("bub_srcB", d_srcB, 64'hF);
        chk("bub_dstE", d_dstE, 64'hF);
        chk("bub_dstM", d_dstM, 64'hF);
        chk("bub_stat", d_stat, 64'h0);

        // async reset between edges, held across an edge with a pending write
        set_f(4'h3, 4'h0, 4'hF, 4'h7, 64'h77, 64'h0A, 2'd0);
        tick();
        chk("pre_rst_icode", d_icode, 64'h3);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_icode", d_icode, 64'h1);
        chk("async_rst_valC", d_valC, 64'h0);
        set_w(4'h2, 64'hFF, 4'h5, 64'hEE);
        d_stall = 1'b1;
        tick();
        rst = 1'b0; d_stall = 1'b0;
        set_w(4'hF, 64'd0, 4'hF, 64'd0);
        set_f(4'h4, 4'h0, 4'h5, 4'h2, 64'h0, 64'h0, 2'd0);
        tick();
        chk("rst_r5_zero", d_valA, 64'h0);
        chk("rst_r2_zero", d_valB, 64'h0);

        // invalid icode with nonzero r5
        set_w(4'h5, 64'h7, 4'hF, 64'd0);
        tick();
        set_w(4'hF, 64'd0, 4'hF, 64'd0);
        set_f(4'hC, 4'h0, 4'h5, 4'h5, 64'h0, 64'h0, 2'd3);
        tick();
        chk("ins_stat", d_stat, 64'h3);
        chk("ins_valA", d_valA, 64'h0);
        chk("ins_valB", d_valB, 64'h0);
        chk("ins_srcA", d_srcA, 64'hF);
        chk("ins_dstE", d_dstE, 64'hF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
